// File: rtl/data_mem_if.sv
// MEM-stage data memory bus: EX/MEM request fields in, load result and status out.
interface data_mem_if;
   logic [63:0] addr;
   logic [63:0] write_data;
   logic        memread;
   logic        memwrite;
   logic [2:0]  funct3;
   logic [63:0] read_data;
   logic        misaligned;
   logic        err_sticky;
   logic [15:0] store_count;

   modport master (
      output addr, write_data, memread, memwrite, funct3,
      input  read_data, misaligned, err_sticky, store_count
   );

   modport slave (
      input  addr, write_data, memread, memwrite, funct3,
      output read_data, misaligned, err_sticky, store_count
   );
endinterface

// File: rtl/data_mem_stage.sv
// Byte-addressable little-endian data RAM for the RV64I MEM stage: combinational sized loads,
// byte-masked stores on the clock edge, misalignment/illegal-encoding flagging with a sticky error.
module data_mem_stage #(
   parameter int unsigned DEPTH_BYTES = 256,
   parameter int unsigned IDX_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   data_mem_if.slave  bus
);

   logic [7:0]       mem_q [DEPTH_BYTES];
   logic [7:0]       mem_d [DEPTH_BYTES];
   logic             err_sticky_q, err_sticky_d;
   logic [15:0]      store_count_q, store_count_d;

   logic [IDX_W-1:0] idx;
   logic [7:0]       byte_en;
   logic             align_bad;
   logic             illegal;
   logic             flag;
   logic             store_en;
   logic [63:0]      raw;
   logic [63:0]      ext;
   logic             unused_addr;

   // Upper address bits alias modulo DEPTH_BYTES.
   assign unused_addr = ^bus.addr[63:IDX_W];

   always_comb begin
      idx           = bus.addr[IDX_W-1:0];
      byte_en       = 8'h01;
      align_bad     = 1'b0;
      raw           = '0;
      ext           = '0;
      mem_d         = mem_q;
      store_count_d = store_count_q;

      unique case (bus.funct3[1:0])
         2'b00: begin byte_en = 8'h01; align_bad = 1'b0;                  end
         2'b01: begin byte_en = 8'h03; align_bad = bus.addr[0];           end
         2'b10: begin byte_en = 8'h0F; align_bad = |bus.addr[1:0];        end
         2'b11: begin byte_en = 8'hFF; align_bad = |bus.addr[2:0];        end
      endcase

      illegal  = (bus.memread && bus.funct3 == 3'b111) || (bus.memwrite && bus.funct3[2]);
      flag     = (bus.memread || bus.memwrite) && (align_bad || illegal);
      store_en = bus.memwrite && !flag;

      for (int k = 0; k < 8; k++) begin
         if (byte_en[k]) raw[8*k +: 8] = mem_q[idx + IDX_W'(k)];
      end

      case (bus.funct3)
         3'b000:  ext = {{56{raw[7]}},  raw[7:0]};
         3'b001:  ext = {{48{raw[15]}}, raw[15:0]};
         3'b010:  ext = {{32{raw[31]}}, raw[31:0]};
         3'b011:  ext = raw;
         3'b100:  ext = {56'd0, raw[7:0]};
         3'b101:  ext = {48'd0, raw[15:0]};
         3'b110:  ext = {32'd0, raw[31:0]};
         default: ext = '0;
      endcase

      if (store_en) begin
         for (int k = 0; k < 8; k++) begin
            if (byte_en[k]) mem_d[idx + IDX_W'(k)] = bus.write_data[8*k +: 8];
         end
         store_count_d = store_count_q + 16'd1;
      end

      err_sticky_d = err_sticky_q | flag;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q         <= '{default: '0};
         err_sticky_q  <= 1'b0;
         store_count_q <= '0;
      end else begin
         mem_q         <= mem_d;
         err_sticky_q  <= err_sticky_d;
         store_count_q <= store_count_d;
      end
   end

   assign bus.read_data   = (bus.memread && !flag) ? ext : '0;
   assign bus.misaligned  = flag;
   assign bus.err_sticky  = err_sticky_q;
   assign bus.store_count = store_count_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: directed load/store cases plus randomized traffic
// compared against a byte-array reference model.
module tb_data_mem_stage;

   logic clk;
   logic reset;
   data_mem_if bus ();

   data_mem_stage #(
      .DEPTH_BYTES (256),
      .IDX_W       (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [7:0]  mdl [256];
   logic [15:0] mcount;
   logic        msticky;
   logic [63:0] last_rd;
   logic        last_mis;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit m_bad(input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [63:0] a);
      int n = nbytes(f3);
      if (!(rd || wr)) return 1'b0;
      return ((a % 64'(n)) != 0) || (rd && f3 == 3'd7) || (wr && f3 >= 3'd4);
   endfunction

   function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] a);
      int          n    = nbytes(f3);
      int          base = int'(a % 64'd256);
      logic [63:0] v    = 0;
      logic [63:0] mask;
      for (int k = 0; k < n; k++) v = v | (64'(mdl[(base + k) % 256]) << (8 * k));
      mask = (64'd1 << (8 * n)) - 64'd1;
      if (f3 < 3'd3 && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) v = v | ~mask;
      return v;
   endfunction

   task automatic do_cycle(input bit rst, input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd, input bit chk);
      bit          bad;
      logic [63:0] exp_rd;
      int          base;
      @(negedge clk);
      reset          = rst;
      bus.memread    = rd;
      bus.memwrite   = wr;
      bus.funct3     = f3;
      bus.addr       = a;
      bus.write_data = wd;
      #1;
      bad    = m_bad(rd, wr, f3, a);
      exp_rd = (rd && !bad) ? m_load(f3, a) : 64'd0;
      if (chk) begin
         check_eq("read_data", bus.read_data, exp_rd);
         check_eq("misaligned", 64'(bus.misaligned), 64'(bad));
         check_eq("err_sticky", 64'(bus.err_sticky), 64'(msticky));
         check_eq("store_count", 64'(bus.store_count), 64'(mcount));
      end
      last_rd  = bus.read_data;
      last_mis = bus.misaligned;
      if (rst) begin
         for (int i = 0; i < 256; i++) mdl[i] = 8'd0;
         mcount  = 16'd0;
         msticky = 1'b0;
      end else if (bad) begin
         msticky = 1'b1;
      end else if (wr) begin
         base = int'(a % 64'd256);
         for (int k = 0; k < nbytes(f3); k++) mdl[(base + k) % 256] = wd[8*k +: 8];
         mcount = mcount + 16'd1;
      end
      @(posedge clk);
   endtask

   initial begin
      reset = 1'b1;
      bus.memread = 1'b0; bus.memwrite = 1'b0; bus.funct3 = 3'd0;
      bus.addr = '0; bus.write_data = '0;
      mcount = 16'd0; msticky = 1'b0;

      do_cycle(1, 0, 0, 3'd0, 64'h0, 64'h0, 0);
      #1;
      check_eq("rst_sticky", 64'(bus.err_sticky), 64'd0);
      check_eq("rst_count", 64'(bus.store_count), 64'd0);
      check_eq("rst_rd", bus.read_data, 64'd0);
      check_eq("rst_mis", 64'(bus.misaligned), 64'd0);

      do_cycle(0, 0, 1, 3'd3, 64'h10, 64'h1122334455667788, 1);
      do_cycle(0, 1, 0, 3'd3, 64'h10, 64'h0, 1);
      check_eq("ld_after_sd", last_rd, 64'h1122334455667788);
      check_eq("count_one", 64'(bus.store_count), 64'd1);
      do_cycle(0, 1, 0, 3'd0, 64'h10, 64'h0, 1);
      check_eq("lb", last_rd, 64'hFFFFFFFFFFFFFF88);
      do_cycle(0, 1, 0, 3'd4, 64'h10, 64'h0, 1);
      check_eq("lbu", last_rd, 64'h88);
      do_cycle(0, 1, 0, 3'd1, 64'h12, 64'h0, 1);
      check_eq("lh", last_rd, 64'h5566);
      do_cycle(0, 1, 0, 3'd2, 64'h14, 64'h0, 1);
      check_eq("lw", last_rd, 64'h11223344);

      do_cycle(0, 0, 1, 3'd0, 64'h13, 64'hAB, 1);
      do_cycle(0, 1, 0, 3'd3, 64'h10, 64'h0, 1);
      check_eq("ld_after_sb", last_rd, 64'h11223344AB667788);
      do_cycle(0, 1, 0, 3'd6, 64'h10, 64'h0, 1);
      check_eq("lwu", last_rd, 64'hAB667788);
      do_cycle(0, 1, 0, 3'd2, 64'h10, 64'h0, 1);
      check_eq("lw_neg", last_rd, 64'hFFFFFFFFAB667788);

      do_cycle(0, 0, 1, 3'd2, 64'h21, 64'hDEADBEEF, 1);
      check_eq("sw_misaligned", 64'(last_mis), 64'd1);
      do_cycle(0, 1, 0, 3'd3, 64'h20, 64'h0, 1);
      check_eq("sw_no_write", last_rd, 64'd0);
      check_eq("sticky_set", 64'(bus.err_sticky), 64'd1);
      check_eq("count_held", 64'(bus.store_count), 64'd2);

      do_cycle(0, 0, 1, 3'd3, 64'h100, 64'hCAFE, 1);
      do_cycle(0, 1, 0, 3'd3, 64'h0, 64'h0, 1);
      check_eq("alias", last_rd, 64'hCAFE);
      do_cycle(0, 1, 1, 3'd3, 64'h8, 64'h5555AAAA5555AAAA, 1);
      check_eq("rdw_old", last_rd, 64'd0);
      do_cycle(0, 1, 0, 3'd3, 64'h8, 64'h0, 1);
      check_eq("rdw_new", last_rd, 64'h5555AAAA5555AAAA);

      do_cycle(1, 0, 1, 3'd3, 64'h10, 64'hFFFFFFFFFFFFFFFF, 1);
      do_cycle(0, 1, 0, 3'd3, 64'h10, 64'h0, 1);
      check_eq("rst_cleared", last_rd, 64'd0);
      check_eq("rst_sticky2", 64'(bus.err_sticky), 64'd0);
      check_eq("rst_count2", 64'(bus.store_count), 64'd0);

      for (int i = 0; i < 600; i++) begin
         logic [63:0] a;
         logic [1:0]  op;
         a  = {$urandom(), $urandom()};
         if ($urandom_range(0, 3) != 0) a[2:0] = 3'd0;
         op = 2'($urandom_range(0, 3));
         do_cycle(($urandom_range(0, 63) == 0), op[0], op[1], 3'($urandom_range(0, 7)), a,
                  {$urandom(), $urandom()}, 1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
